jtag_test_data_register: RTL and testbench

Parametrised JTAG test data register (TDR) with capture, shift and update stages. It generalises the fixed-ID data register to any WIDTH. Capture loads either a fixed identification code or a live parallel input. A separate update/hold stage drives system logic, and the block checks shift length and control protocol. It sits between the TAP controller's DR control strobes and chip-side user/instrument logic, and is selected by the instruction decoder.

---
 rtl/jtag_test_data_register.sv | 77 +++++++
 tb/tb_jtag_test_data_register.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_test_data_register.sv
// Parametrised JTAG test data register: capture / shift / update stages
// with shift-length and strobe-protocol checking.
module jtag_test_data_register #(
    parameter int                WIDTH          = 32,
    parameter logic [WIDTH-1:0]  ID_VALUE       = WIDTH'(32'h0000_0001),
    parameter int                ENFORCE_ID_LSB = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0
) (
    input  logic                         tck,
    input  logic                         reset,
    input  logic                         tdi,
    input  logic                         capture_dr,
    input  logic                         shift_dr,
    input  logic                         update_dr,
    input  logic                         sel_id,
    input  logic [WIDTH-1:0]             parallel_in,
    output logic                         tdo,
    output logic [WIDTH-1:0]             parallel_out,
    output logic                         update_pulse,
    output logic [$clog2(WIDTH+2)-1:0]   shift_count,
    output logic                         length_err,
    output logic                         proto_err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "jtag_test_data_register: WIDTH must be >= 2");
    end

    // IEEE 1149.1 identification codes always carry a 1 in bit 0
    if (ENFORCE_ID_LSB != 0 && ID_VALUE[0] != 1'b1) begin : g_bad_id
        $fatal(1, "jtag_test_data_register: ID_VALUE[0] must be 1");
    end

    logic [WIDTH-1:0] shift_reg;
    logic             multi;

    assign multi = (capture_dr & shift_dr) |
                   (capture_dr & update_dr) |
                   (shift_dr & update_dr);

    assign tdo = shift_reg[0];

    always_ff @(posedge tck) begin
        if (reset) begin
            shift_reg    <= '0;
            parallel_out <= RESET_VALUE;
            shift_count  <= '0;
            update_pulse <= 1'b0;
            length_err   <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (multi) begin
                proto_err <= 1'b1;
            end
            // capture outranks shift, shift outranks update
            if (capture_dr) begin
                shift_reg   <= sel_id ? ID_VALUE : parallel_in;
                shift_count <= '0;
            end else if (shift_dr) begin
                shift_reg <= {tdi, shift_reg[WIDTH-1:1]};
                if (shift_count != SAT) begin
                    shift_count <= shift_count + 1'b1;
                end
            end else if (update_dr) begin
                parallel_out <= shift_reg;
                update_pulse <= 1'b1;
                length_err   <= (shift_count != FULL);
            end
        end
    end

endmodule

// File: tb/tb_jtag_test_data_register.sv
// Directed self-checking bench for jtag_test_data_register.
module tb_jtag_test_data_register;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h5A5A_0F0F;

    logic          tck = 1'b0;
    logic          reset = 1'b0;
    logic          tdi = 1'b0;
    logic          capture_dr = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          sel_id = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic          tdo;
    logic [W-1:0]  parallel_out;
    logic          update_pulse;
    logic [5:0]    shift_count;
    logic          length_err;
    logic          proto_err;

    int n_cmp = 0;
    int n_err = 0;

    jtag_test_data_register #(
        .WIDTH(W),
        .RESET_VALUE(RV)
    ) dut (
        .tck(tck),
        .reset(reset),
        .tdi(tdi),
        .capture_dr(capture_dr),
        .shift_dr(shift_dr),
        .update_dr(update_dr),
        .sel_id(sel_id),
        .parallel_in(parallel_in),
        .tdo(tdo),
        .parallel_out(parallel_out),
        .update_pulse(update_pulse),
        .shift_count(shift_count),
        .length_err(length_err),
        .proto_err(proto_err)
    );

    always #5 tck = ~tck;

    // one clock: drive on the falling edge, sample 1 ns after the rising edge
    task automatic cyc(input logic c, input logic s, input logic u, input logic d);
        @(negedge tck);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        tdi        = d;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_n(input int n, input logic [W-1:0] pat, output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            if (i < W) got[i] = tdo;
            cyc(1'b0, 1'b1, 1'b0, pat[i % W]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL rst_tdo got %b want 0", tdo); end
        n_cmp++; if (parallel_out !== RV) begin n_err++; $display("FAIL rst_pout got %h want %h", parallel_out, RV); end
        n_cmp++; if (shift_count !== 6'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", shift_count); end
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse got %b want 0", update_pulse); end
        n_cmp++; if (length_err !== 1'b0) begin n_err++; $display("FAIL rst_len got %b want 0", length_err); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_proto got %b want 0", proto_err); end
        reset = 1'b0;
    endtask

    task automatic test_id_shift();
        logic [W-1:0] got;
        sel_id = 1'b1;
        parallel_in = 32'hFFFF_FFFE;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        sel_id = 1'b0;
        n_cmp++; if (shift_count !== 6'd0) begin n_err++; $display("FAIL id_cnt0 got %0d want 0", shift_count); end
        shift_n(32, 32'h0, got);
        n_cmp++; if (got !== 32'h0000_0001) begin n_err++; $display("FAIL id_tdo got %h want 00000001", got); end
        n_cmp++; if (shift_count !== 6'd32) begin n_err++; $display("FAIL id_cnt got %0d want 32", shift_count); end
        n_cmp++; if (parallel_out !== RV) begin n_err++; $display("FAIL id_pout got %h want %h", parallel_out, RV); end
    endtask

    task automatic test_shift_update();
        logic [W-1:0] got;
        parallel_in = 32'h1234_5678;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(32, 32'hA5A5_A5A5, got);
        n_cmp++; if (got !== 32'h1234_5678) begin n_err++; $display("FAIL su_tdo got %h want 12345678", got); end
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL su_pre_pulse got %b want 0", update_pulse); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (parallel_out !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL su_pout got %h want a5a5a5a5", parallel_out); end
        n_cmp++; if (update_pulse !== 1'b1) begin n_err++; $display("FAIL su_pulse got %b want 1", update_pulse); end
        n_cmp++; if (length_err !== 1'b0) begin n_err++; $display("FAIL su_len got %b want 0", length_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL su_pulse_end got %b want 0", update_pulse); end
    endtask

    task automatic test_length();
        logic [W-1:0] got;
        parallel_in = 32'hC000_0000;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(31, 32'h0, got);
        n_cmp++; if (shift_count !== 6'd31) begin n_err++; $display("FAIL len_cnt31 got %0d want 31", shift_count); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (length_err !== 1'b1) begin n_err++; $display("FAIL len_short got %b want 1", length_err); end
        n_cmp++; if (parallel_out !== 32'h0000_0001) begin n_err++; $display("FAIL len_short_pout got %h want 00000001", parallel_out); end
        parallel_in = 32'h1234_5678;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(34, 32'hFFFF_FFFF, got);
        n_cmp++; if (shift_count !== 6'd33) begin n_err++; $display("FAIL len_sat got %0d want 33", shift_count); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (length_err !== 1'b1) begin n_err++; $display("FAIL len_long got %b want 1", length_err); end
        n_cmp++; if (parallel_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL len_long_pout got %h want ffffffff", parallel_out); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        parallel_in = 32'h0F0F_1234;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(32, 32'h3C3C_00FF, got);
        n_cmp++; if (got !== 32'h0F0F_1234) begin n_err++; $display("FAIL b2b_tdo got %h want 0f0f1234", got); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (update_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_pulse1 got %b want 1", update_pulse); end
        n_cmp++; if (parallel_out !== 32'h3C3C_00FF) begin n_err++; $display("FAIL b2b_pout got %h want 3c3c00ff", parallel_out); end
        n_cmp++; if (length_err !== 1'b0) begin n_err++; $display("FAIL b2b_len1 got %b want 0", length_err); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (update_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_pulse2 got %b want 1", update_pulse); end
        n_cmp++; if (length_err !== 1'b0) begin n_err++; $display("FAIL b2b_len2 got %b want 0", length_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_end got %b want 0", update_pulse); end
    endtask

    task automatic test_proto();
        logic [W-1:0] got;
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL pr_clean got %b want 0", proto_err); end
        parallel_in = 32'hDEAD_BEEF;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (shift_count !== 6'd0) begin n_err++; $display("FAIL pr_cnt got %0d want 0", shift_count); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL pr_set got %b want 1", proto_err); end
        shift_n(32, 32'h0, got);
        n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pr_data got %h want deadbeef", got); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (parallel_out !== 32'h0) begin n_err++; $display("FAIL pr_pout got %h want 00000000", parallel_out); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL pr_sticky got %b want 1", proto_err); end
        // shift beats update: no pulse, parallel_out untouched
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL pr_su_pulse got %b want 0", update_pulse); end
        n_cmp++; if (parallel_out !== 32'h0) begin n_err++; $display("FAIL pr_su_pout got %h want 00000000", parallel_out); end
        n_cmp++; if (shift_count !== 6'd33) begin n_err++; $display("FAIL pr_su_cnt got %0d want 33", shift_count); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        parallel_in = 32'h1234_5678;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(10, 32'hFFFF_FFFF, got);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (length_err !== 1'b1) begin n_err++; $display("FAIL rm_len_pre got %b want 1", length_err); end
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL rm_tdo got %b want 0", tdo); end
        n_cmp++; if (shift_count !== 6'd0) begin n_err++; $display("FAIL rm_cnt got %0d want 0", shift_count); end
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL rm_pulse got %b want 0", update_pulse); end
        n_cmp++; if (length_err !== 1'b0) begin n_err++; $display("FAIL rm_len got %b want 0", length_err); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rm_proto got %b want 0", proto_err); end
        n_cmp++; if (parallel_out !== RV) begin n_err++; $display("FAIL rm_pout got %h want %h", parallel_out, RV); end
        sel_id = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        sel_id = 1'b0;
        shift_n(32, 32'hFFFF_FFFF, got);
        n_cmp++; if (got !== 32'h0000_0001) begin n_err++; $display("FAIL ru_id got %h want 00000001", got); end
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL ru_pulse got %b want 0", update_pulse); end
        n_cmp++; if (parallel_out !== RV) begin n_err++; $display("FAIL ru_pout got %h want %h", parallel_out, RV); end
        n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL ru_tdo got %b want 0", tdo); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (update_pulse !== 1'b0) begin n_err++; $display("FAIL ru_pulse_after got %b want 0", update_pulse); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_id_shift();
        test_shift_update();
        test_length();
        test_back_to_back();
        test_proto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
